osd_reg_responder: RTL
======================

OSD_REG_RESPONDER -- requirements
Module: osd_reg_responder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles to wait for register completion before reporting an error.
REQ-002 SHALL have ports clk and rst: one clock; rst is synchronous and active-high.
REQ-003 SHALL have input id, 10 bits: own debug address, zero-extended to 16 bits on the wire.
REQ-004 SHALL have debug_in, a dii_channel.slave (data[15:0], last, valid, ready), receiving request packets from a router local_out.
REQ-005 SHALL have debug_out, a dii_channel.master, sending response packets to a router local_in.
REQ-006 SHALL have output reg_request (1 bit): register access in progress.
REQ-007 SHALL have output reg_write (1 bit): 1 for a write, 0 for a read.
REQ-008 SHALL have outputs reg_addr (16 bits) and reg_wdata (16 bits).
REQ-009 SHALL have inputs reg_ack, reg_err and reg_rdata[15:0] (completion, failure, read data).

Function
REQ-010 SHALL define the packet layout as: word0 dest, word1 src, word2 flags[15:14]=type (REG=2'b00), flags[13:10]=subtype, flags[9:0]=0, then payload.
REQ-011 SHALL use these subtypes: REQ_READ=0000, REQ_WRITE=0010, RESP_READ=1000, RESP_READ_ERR=1001, RESP_WRITE=1010, RESP_WRITE_ERR=1011.
REQ-012 SHALL accept the following as valid requests; any other packet is malformed:
- REQ_READ: 4 words (address).
- REQ_WRITE: 5 words (address, wdata).
- Last asserted only on the final word; type REG.
REQ-013 SHALL implement states RX_DEST, RX_SRC, RX_FLAGS, RX_ADDR, RX_WDATA, RX_DRAIN, ACCESS, TX_DEST, TX_SRC, TX_FLAGS, TX_DATA.
REQ-014 SHALL assert debug_in.ready only in RX_* states, advancing one state per valid&&ready word.
REQ-015 SHALL handle malformed packets as follows, with no response and no register access:
- Early last: return to RX_DEST.
- Missing last on the final required word, or bad type/subtype: go to RX_DRAIN, discard until last, then return to RX_DEST.
REQ-016 SHALL ignore the dest word contents; routing is the router's job.
REQ-017 SHALL, in ACCESS, hold reg_request=1 with stable reg_write, reg_addr and reg_wdata until reg_ack, reg_err or timeout; reg_request drops the cycle after completion.
REQ-018 SHALL treat simultaneous reg_ack and reg_err as an error.
REQ-019 SHALL count ACCESS cycles and treat TIMEOUT_CYCLES cycles without completion as an error; the counter clears on ACCESS entry.
REQ-020 SHALL send the response as:
- dest = request src.
- src = {6'b0,id}.
- flags = matching RESP subtype.
- Read success only: a 4th word carrying captured reg_rdata.
- last set on the final word.
REQ-021 SHALL hold debug_out.data/last stable while valid && !ready; a TX state advances only on valid&&ready.
REQ-022 SHALL return to RX_DEST after the final response word is accepted; a new request is never accepted while a response is pending.
REQ-023 SHALL give a minimum request-last-accepted to debug_out.valid latency of 2 cycles (ACCESS entry, plus at least one ACCESS cycle).

Reset
REQ-024 SHALL, on rst, enter RX_DEST with debug_in.ready=1, debug_out.valid=0, debug_out.last=0, reg_request=0, timeout counter=0.
REQ-025 SHALL let rst abort any in-flight packet or access without emitting a response; leftover words of an aborted packet are parsed as a new packet.

Structure
REQ-026 SHALL take type/subtype encodings and word-index constants from the shared package osd_reg_pkg; the state enum stays local.
REQ-027 SHALL be a single module with no sub-modules.

Verification
REQ-028 Read: id=5, packet {0005,0003,0000,0040 last}, reg_rdata=BEEF ack 3 cycles later -> reg_addr=0040, reg_write=0; response {0003,0005,2000,BEEF last}.
REQ-029 Write: {0005,0003,0800,0010,1234 last}, ack -> reg_write=1, reg_wdata=1234; response {0003,0005,2800 last}.
REQ-030 Timeout: TIMEOUT_CYCLES=8, read with no ack -> reg_request high exactly 8 cycles; response flags 2400.
REQ-031 Malformed: last on word2, then a bad subtype 3C00 with 6 words -> no reg_request, no debug_out.valid; a following valid read is serviced normally.
REQ-032 Backpressure: debug_out.ready toggled 1-0-0-1 -> each response word held stable, none lost or duplicated; debug_in.ready=0 throughout TX.
REQ-033 Reset mid-access: rst during ACCESS -> reg_request=0 and debug_out.valid=0 next cycle, and no response is ever emitted.

Source files
------------

// File: rtl/osd_reg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : osd_reg_pkg
//  Description : Shared encodings for OSD register-access packets: packet
//                type and subtype codes, word positions inside a packet,
//                request lengths and helpers that build a flags word.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package osd_reg_pkg;

    // Packet type carried in flags[15:14]
    localparam logic [1:0] c_type_reg = 2'b00;

    // Subtypes carried in flags[13:10]
    localparam logic [3:0] c_sub_req_read       = 4'b0000;
    localparam logic [3:0] c_sub_req_write      = 4'b0010;
    localparam logic [3:0] c_sub_resp_read      = 4'b1000;
    localparam logic [3:0] c_sub_resp_read_err  = 4'b1001;
    localparam logic [3:0] c_sub_resp_write     = 4'b1010;
    localparam logic [3:0] c_sub_resp_write_err = 4'b1011;

    // Word positions inside a packet
    localparam int c_word_dest  = 0;
    localparam int c_word_src   = 1;
    localparam int c_word_flags = 2;
    localparam int c_word_addr  = 3;
    localparam int c_word_wdata = 4;

    // Total request lengths in words
    localparam int c_len_req_read  = 4;
    localparam int c_len_req_write = 5;

    // Flags word: type, subtype, ten reserved zero bits
    function automatic logic [15:0] make_flags(input logic [1:0] ptype,
                                               input logic [3:0] sub);
        return {ptype, sub, 10'b0};
    endfunction

    // Response subtype for a completed access
    function automatic logic [3:0] resp_subtype(input logic write,
                                                input logic err);
        logic [3:0] sub;
        case ({write, err})
            2'b00:   sub = c_sub_resp_read;
            2'b01:   sub = c_sub_resp_read_err;
            2'b10:   sub = c_sub_resp_write;
            default: sub = c_sub_resp_write_err;
        endcase
        return sub;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dii_channel.sv
`default_nettype none
// ============================================================================
//  Module      : dii_channel
//  Description : Debug interconnect word channel with valid/ready handshake
//                and an end-of-packet marker.
//  Ports       : data[15:0], last, valid (master->slave), ready (slave->master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dii_channel;
    logic [15:0] data;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, output last, output valid, input ready);
    modport slave  (input data, input last, input valid, output ready);
endinterface
`default_nettype wire

// File: rtl/osd_reg_responder.sv
`default_nettype none
// ============================================================================
//  Module      : osd_reg_responder
//  Description : Receives register read/write request packets from the debug
//                interconnect, performs the access on a simple request/ack
//                register port (with timeout), and returns a response packet
//                to the requester.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                id[9:0]         - own debug address
//                debug_in        - request packets in (slave)
//                debug_out       - response packets out (master)
//                reg_request     - register access in progress
//                reg_write       - 1 write / 0 read
//                reg_addr/wdata  - access address and write data
//                reg_ack/err     - access completion / failure
//                reg_rdata       - read data
//  Revision    : 1.0 - initial release
// ============================================================================
module osd_reg_responder
    import osd_reg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       id,
    dii_channel.slave        debug_in,
    dii_channel.master       debug_out,
    output logic             reg_request,
    output logic             reg_write,
    output logic [15:0]      reg_addr,
    output logic [15:0]      reg_wdata,
    input  logic             reg_ack,
    input  logic             reg_err,
    input  logic [15:0]      reg_rdata
);

    typedef enum logic [3:0] {
        RX_DEST  = 4'd0,
        RX_SRC   = 4'd1,
        RX_FLAGS = 4'd2,
        RX_ADDR  = 4'd3,
        RX_WDATA = 4'd4,
        RX_DRAIN = 4'd5,
        ACCESS   = 4'd6,
        TX_DEST  = 4'd7,
        TX_SRC   = 4'd8,
        TX_FLAGS = 4'd9,
        TX_DATA  = 4'd10
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1
    localparam int c_cnt_w = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [15:0]          r_src;
    logic                 r_write;
    logic [15:0]          r_addr;
    logic [15:0]          r_wdata;
    logic [15:0]          r_rdata;
    logic                 r_err;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_rx;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic                 w_timeout;
    logic                 w_done;
    logic                 w_flags_ok;
    logic                 w_has_data;

    assign w_rx = (r_state == RX_DEST) || (r_state == RX_SRC) ||
                  (r_state == RX_FLAGS) || (r_state == RX_ADDR) ||
                  (r_state == RX_WDATA) || (r_state == RX_DRAIN);

    assign w_in_fire  = debug_in.valid && w_rx;
    assign w_out_fire = debug_out.valid && debug_out.ready;

    // Reaching the last count value in ACCESS means the full budget is spent
    assign w_timeout = (r_cnt == c_cnt_last);
    assign w_done    = reg_ack || reg_err || w_timeout;

    // Reserved flag bits are not checked; only type and subtype select a request
    assign w_flags_ok = (debug_in.data[15:14] == c_type_reg) &&
                        ((debug_in.data[13:10] == c_sub_req_read) ||
                         (debug_in.data[13:10] == c_sub_req_write));

    // Only a successful read carries a payload word
    assign w_has_data = !r_write && !r_err;

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        debug_in.ready  = w_rx;
        debug_out.valid = 1'b0;
        debug_out.last  = 1'b0;
        debug_out.data  = 16'h0000;
        reg_request     = 1'b0;

        case (r_state)
            RX_DEST: begin
                if (w_in_fire) begin
                    w_state_next = debug_in.last ? RX_DEST : RX_SRC;
                end
            end
            RX_SRC: begin
                if (w_in_fire) begin
                    w_state_next = debug_in.last ? RX_DEST : RX_FLAGS;
                end
            end
            RX_FLAGS: begin
                if (w_in_fire) begin
                    if (debug_in.last) begin
                        w_state_next = RX_DEST;
                    end else if (w_flags_ok) begin
                        w_state_next = RX_ADDR;
                    end else begin
                        w_state_next = RX_DRAIN;
                    end
                end
            end
            RX_ADDR: begin
                if (w_in_fire) begin
                    if (r_write) begin
                        w_state_next = debug_in.last ? RX_DEST : RX_WDATA;
                    end else begin
                        w_state_next = debug_in.last ? ACCESS : RX_DRAIN;
                    end
                end
            end
            RX_WDATA: begin
                if (w_in_fire) begin
                    w_state_next = debug_in.last ? ACCESS : RX_DRAIN;
                end
            end
            RX_DRAIN: begin
                if (w_in_fire && debug_in.last) begin
                    w_state_next = RX_DEST;
                end
            end
            ACCESS: begin
                reg_request = 1'b1;
                if (w_done) begin
                    w_state_next = TX_DEST;
                end
            end
            TX_DEST: begin
                debug_out.valid = 1'b1;
                debug_out.data  = r_src;
                if (w_out_fire) begin
                    w_state_next = TX_SRC;
                end
            end
            TX_SRC: begin
                debug_out.valid = 1'b1;
                debug_out.data  = {6'b0, id};
                if (w_out_fire) begin
                    w_state_next = TX_FLAGS;
                end
            end
            TX_FLAGS: begin
                debug_out.valid = 1'b1;
                debug_out.data  = make_flags(c_type_reg, resp_subtype(r_write, r_err));
                debug_out.last  = !w_has_data;
                if (w_out_fire) begin
                    w_state_next = w_has_data ? TX_DATA : RX_DEST;
                end
            end
            TX_DATA: begin
                debug_out.valid = 1'b1;
                debug_out.data  = r_rdata;
                debug_out.last  = 1'b1;
                if (w_out_fire) begin
                    w_state_next = RX_DEST;
                end
            end
            default: begin
                w_state_next = RX_DEST;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_DEST;
            r_src   <= 16'h0000;
            r_write <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
            r_rdata <= 16'h0000;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;

            if (w_in_fire) begin
                case (r_state)
                    RX_SRC:   r_src   <= debug_in.data;
                    RX_FLAGS: r_write <= (debug_in.data[13:10] == c_sub_req_write);
                    RX_ADDR:  r_addr  <= debug_in.data;
                    RX_WDATA: r_wdata <= debug_in.data;
                    default:  ;
                endcase
            end

            // Counter is held at zero outside ACCESS so every access starts fresh
            if (r_state == ACCESS) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
                if (w_done) begin
                    // Anything other than a clean ack (err, ack+err, timeout) is an error
                    r_err   <= reg_err || !reg_ack;
                    r_rdata <= reg_rdata;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign reg_write = r_write;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;

endmodule
`default_nettype wire
